// File: rtl/uart_tx_stream.sv
// uart_tx_stream: parametrised UART transmitter fed by a valid/ready FIFO.
// Optional line break generation via `define UART_TX_BREAK_EN (send_break).

module uart_tx_stream #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_BITS-1:0]         s_data,
  output logic                         tx,
  output logic                         tx_busy,
  output logic                         frame_done,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                         send_break
`endif
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(BAUD_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic          PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_BREAK,
    S_GAP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count_q;
  logic                 push;
  logic                 pop;
  logic                 empty;
  logic [DATA_BITS-1:0] head;

  state_t               state_q, state_n;
  logic [CW-1:0]        cnt_q, cnt_n;
  logic [BW-1:0]        bit_q, bit_n;
  logic [DATA_BITS-1:0] sh_q, sh_n;
  logic                 par_q, par_n;
  logic                 tx_q, tx_n;
  logic                 bit_end;

  assign s_ready    = (count_q < FULL_CNT);
  assign push       = s_valid && s_ready;
  assign empty      = (count_q == '0);
  assign head       = mem[rd_ptr];
  assign fifo_count = count_q;
  assign tx         = tx_q;
  assign tx_busy    = !(state_q == S_IDLE || state_q == S_GAP);
  assign bit_end    = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bit_q   <= bit_n;
      sh_q    <= sh_n;
      par_q   <= par_n;
      tx_q    <= tx_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    cnt_n      = '0;
    bit_n      = bit_q;
    sh_n       = sh_q;
    par_n      = par_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    if (state_q != S_IDLE && state_q != S_BREAK)
      cnt_n = bit_end ? '0 : cnt_q + CW'(1);
    unique case (state_q)
      S_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (send_break) state_n = S_BREAK;
        else
`endif
        if (!empty) pop = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          bit_n   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          sh_n = sh_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_n = bit_q + BW'(1);
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_n = S_STOP;
          bit_n   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            frame_done = 1'b1;
            bit_n      = '0;
            state_n    = S_IDLE;
`ifdef UART_TX_BREAK_EN
            if (send_break) state_n = S_BREAK;
            else
`endif
            if (!empty) pop = 1'b1;
          end else begin
            bit_n = bit_q + BW'(1);
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        if (!send_break) state_n = S_GAP;
      end
      // one idle bit time after break release before the next start bit
      S_GAP: begin
        if (bit_end) begin
          if (send_break) state_n = S_BREAK;
          else if (!empty) pop = 1'b1;
          else state_n = S_IDLE;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
    if (pop) begin
      state_n = S_START;
      cnt_n   = '0;
      bit_n   = '0;
      sh_n    = head;
      par_n   = (^head) ^ PAR_ODD;
    end
  end

  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      S_START: tx_n = 1'b0;
      S_BREAK: tx_n = 1'b0;
      S_DATA:  tx_n = sh_n[0];
      S_PAR:   tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
Parametrised UART transmitter, the next generation of the team's fixed 8N1 transmitter. Configurable data width, parity and stop bits, plus an internal TX FIFO behind a valid/ready stream input. Sits between the matrix calculator's result formatter and the board TX pin. Sends FIFO contents as back-to-back frames with no idle gap between them.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s; BAUD_DIV = CLK_FREQ / BAUD_RATE (integer division), legal range >= 2
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, TX FIFO entries; power of 2, >= 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
s_valid  in  1  input word valid
s_ready  out  1  FIFO can accept a word; equals (fifo_count < FIFO_DEPTH)
s_data  in  DATA_BITS  input word; transmitted LSB first
tx  out  1  serial line, idle high, registered
tx_busy  out  1  high while a frame is on the line (state != IDLE)
frame_done  out  1  one-cycle pulse on the last cycle of the final stop bit
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst high at a clock edge): tx=1, tx_busy=0, frame_done=0, fifo_count=0, s_ready=1 after the edge. FSM goes to IDLE and the baud counter clears.
- Reset mid-frame: the current frame is aborted. tx returns high on that edge, and all FIFO contents are discarded.
- Push: a word is written when s_valid && s_ready at a clock edge. s_data is ignored when there is no handshake.
- Pop: the FSM reads the FIFO head in IDLE, or at the end of the last stop bit, whenever fifo_count > 0.
- Simultaneous push and pop in one cycle: fifo_count is unchanged.
- When full, s_ready=0, including in a cycle where a pop is happening. There is no full-pass-through.
- FSM states: IDLE -> START -> DATA -> [PARITY if PARITY != 0] -> STOP -> IDLE, or STOP -> START if the FIFO is non-empty.
- Every bit occupies exactly BAUD_DIV clk cycles. The baud counter runs 0..BAUD_DIV-1 and the bit advances when it reaches BAUD_DIV-1.
- Latency: a word pushed at edge E0 into an idle, empty block is popped at edge E1. tx goes low (start bit) after E1.
- DATA: bit index runs 0..DATA_BITS-1, LSB first.
- PARITY: the parity bit is the XOR of the data bits, inverted for odd parity. Odd parity makes the total number of ones (data + parity) odd; even parity makes it even.
- STOP: tx=1 for STOP_BITS * BAUD_DIV cycles.
- frame_done is asserted on the final cycle of STOP. If the FIFO is non-empty at that edge, the next start bit begins on the following cycle, so there is zero idle time and tx_busy stays high.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * BAUD_DIV cycles.
- FIFO: circular buffer with pointers that wrap modulo FIFO_DEPTH. Words leave in strict FIFO order.

Optional Feature:
UART_TX_BREAK_EN
- Defined: adds input port send_break (1 bit).
- While send_break=1 and the FSM is in IDLE, tx is driven 0, tx_busy=1, and no pop occurs.
- Raising send_break mid-frame has no effect until that frame's STOP completes. The FSM then holds break instead of popping.
- When send_break falls, tx returns to 1 and the block stays in IDLE for one full bit time (BAUD_DIV cycles) before any pop.
- Not defined: the port does not exist and the behaviour is exactly as above.

Test Plan:
1. BAUD_DIV=16 (CLK_FREQ=16, BAUD_RATE=1), 8N1, push 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 16 cycles; frame_done pulses 160 cycles after tx first falls; tx_busy returns to 0 the next cycle.
2. DATA_BITS=8, PARITY=2, push 0x07 -> parity bit 1. PARITY=1, push 0x07 -> parity bit 0. Frame is 11 bits = 176 cycles.
3. DATA_BITS=7, STOP_BITS=2, PARITY=0, push 0x55 -> tx sequence 0,1,0,1,0,1,0,1,1,1. Frame is 10 bits = 160 cycles.
4. FIFO_DEPTH=4, hold s_valid=1 with words 0x01..0x06 while the first frame is active -> s_ready drops at fifo_count=4. Six frames go out in order with no gap: next start bit on the cycle after each frame_done.
5. Assert rst for 1 cycle halfway through frame 2 of a 3-word burst -> tx=1 after that edge, fifo_count=0, no further frames, s_ready=1.
6. With UART_TX_BREAK_EN: raise send_break during a frame -> frame completes, tx=0 while held. On release, tx=1 for 16 cycles, then the queued word starts.
